// File: rtl/sr_lut_patch_indexer.sv
// rtl/sr_lut_patch_indexer.sv - streaming 2x2 patch builder with LUT index/fraction split
module sr_lut_patch_indexer #(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_pix,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pix,
    output logic [4*(8-FRAC_BITS)-1:0] out_idx,
    output logic [4*FRAC_BITS-1:0]     out_frac,
    output logic                       out_last,
    output logic                       err_frame
);

    localparam int IW = 8 - FRAC_BITS;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    localparam logic [0:0] S_FILL   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    linebuf [IMG_W];
    logic [7:0]    prev_top;
    logic [7:0]    prev_cur;
    logic [7:0]    top;
    logic          accept;
    logic          at_end;
    logic          emit;
    logic [7:0]    lane [4];
    logic [7:0]    ulane [4];
    logic [4*IW-1:0]        nxt_idx;
    logic [4*FRAC_BITS-1:0] nxt_frac;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign top      = linebuf[col];
    assign at_end   = (row == ROW_MAX) && (col == COL_MAX);
    assign emit     = (state == S_STREAM) && (col != '0);

    // Re-bias each patch pixel to unsigned and slice into index and fraction lanes (a in the top lane)
    always_comb begin
        nxt_idx  = '0;
        nxt_frac = '0;
        lane[0]  = prev_top;
        lane[1]  = top;
        lane[2]  = prev_cur;
        lane[3]  = in_pix;
        for (int k = 0; k < 4; k++) begin
            ulane[k] = lane[k] ^ 8'h80;
            nxt_idx[(3-k)*IW +: IW]               = ulane[k][7:FRAC_BITS];
            nxt_frac[(3-k)*FRAC_BITS +: FRAC_BITS] = ulane[k][FRAC_BITS-1:0];
        end
    end

    // Line buffer: holds the previous line, read before overwrite at the same column
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf[col] <= in_pix;
        end
    end

    // Raster position, FSM, left-neighbour registers and sticky framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FILL;
            row       <= '0;
            col       <= '0;
            prev_top  <= '0;
            prev_cur  <= '0;
            err_frame <= 1'b0;
        end else if (accept) begin
            prev_top <= top;
            prev_cur <= in_pix;
            if (in_last) begin
                if (!at_end) begin
                    err_frame <= 1'b1;
                end
                row   <= '0;
                col   <= '0;
                state <= S_FILL;
            end else begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (state == S_FILL && col == COL_MAX) begin
                    state <= S_STREAM;
                end else if (state == S_STREAM && at_end) begin
                    state <= S_FILL;
                end
            end
        end
    end

    // Single output register: load on a patch-producing accept, drain on out_ready otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_idx   <= '0;
            out_frac  <= '0;
            out_last  <= 1'b0;
        end else if (accept && emit) begin
            out_valid <= 1'b1;
            out_pix   <= {prev_top, top, prev_cur, in_pix};
            out_idx   <= nxt_idx;
            out_frac  <= nxt_frac;
            out_last  <= at_end || in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_lut_patch_indexer.sv
// tb/tb_sr_lut_patch_indexer.sv - scoreboard bench for sr_lut_patch_indexer
module tb_sr_lut_patch_indexer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pix = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pix;
    logic [15:0] out_idx;
    logic [15:0] out_frac;
    logic        out_last;
    logic        err_frame;

    sr_lut_patch_indexer #(.IMG_W(8), .IMG_H(8), .FRAC_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_idx(out_idx), .out_frac(out_frac), .out_last(out_last), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pix;
        logic [15:0] idx;
        logic [15:0] frac;
        logic        last;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    bit         stall_en = 0;
    bit         bursty = 0;
    logic [7:0] img [8][8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] p, input logic l);
        exp_t       e;
        logic [7:0] u;
        e.pix  = p;
        e.last = l;
        e.idx  = '0;
        e.frac = '0;
        for (int k = 0; k < 4; k++) begin
            u = p[8*k +: 8] ^ 8'h80;
            e.idx[4*k +: 4]  = u[7:4];
            e.frac[4*k +: 4] = u[3:0];
        end
        return e;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'(r * 8 + c - 64);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = v;
    endtask

    // Expected patches from the image itself, up to and including (er,ec)
    task automatic queue_patches(input int er, input int ec, input bit mark_last,
                                 input bit hand, input logic [15:0] hidx, input logic [15:0] hfrac);
        exp_t e;
        for (int r = 1; r <= er; r++)
            for (int c = 1; c < 8; c++)
                if (r < er || c <= ec) begin
                    e = mk({img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]},
                           mark_last && r == er && c == ec);
                    if (hand) begin
                        e.idx  = hidx;
                        e.frac = hfrac;
                    end
                    q.push_back(e);
                end
    endtask

    task automatic send_pix(input logic [7:0] p, input logic l);
        bit acc;
        int n;
        if (bursty)
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        in_valid = 1'b1;
        in_pix   = p;
        in_last  = l;
        n = 0;
        acc = 0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_img(input int er, input int ec, input bit last_flag);
        for (int r = 0; r <= er; r++)
            for (int c = 0; c < 8; c++)
                if (r < er || c <= ec)
                    send_pix(img[r][c], last_flag && r == er && c == ec);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Downstream ready: always on, or pseudo-random when stalling is enabled
    always @(posedge clk) begin
        #1;
        out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compare every transferred patch with the scoreboard and check hold-while-stalled
    exp_t held;
    bit   held_v = 0;
    always @(negedge clk) begin
        exp_t got, e;
        if (!rst_n) begin
            held_v = 0;
        end else if (out_valid) begin
            got = {out_pix, out_idx, out_frac, out_last};
            if (held_v) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got %h expected %h", got, held);
                end
            end
            if (out_ready) begin
                held_v = 0;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_patch: got %h expected none", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL patch: got pix=%h idx=%h frac=%h last=%b expected pix=%h idx=%h frac=%h last=%b",
                                 got.pix, got.idx, got.frac, got.last, e.pix, e.idx, e.frac, e.last);
                    end
                end
            end else begin
                held_v = 1;
                held   = got;
            end
        end else begin
            held_v = 0;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pix", 64'(out_pix), 64'd0);
        chk("rst_out_idx_frac", {32'd0, out_idx, out_frac}, 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_err_frame", 64'(err_frame), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp frame, free-flowing
        fill_ramp();
        q.push_back(mk(32'hC0C1C8C9, 1'b0));
        queue_patches(7, 7, 1, 0, '0, '0);
        void'(q.pop_back());
        q.delete(1);
        q.push_back(mk({img[6][6], img[6][7], img[7][6], img[7][7]}, 1'b1));
        send_img(7, 7, 1);
        drain();

        // Ramp frame with bursty input and random downstream stalls
        stall_en = 1;
        bursty   = 1;
        queue_patches(7, 7, 1, 0, '0, '0);
        send_img(7, 7, 1);
        drain();
        stall_en = 0;
        bursty   = 0;

        // Constant extremes and 0x35, first two frames end by wrap without in_last
        fill_const(8'h80);
        queue_patches(7, 7, 1, 1, 16'h0000, 16'h0000);
        send_img(7, 7, 0);
        fill_const(8'h7F);
        queue_patches(7, 7, 1, 1, 16'hFFFF, 16'hFFFF);
        send_img(7, 7, 0);
        fill_const(8'h35);
        queue_patches(7, 7, 1, 1, 16'hBBBB, 16'h5555);
        send_img(7, 7, 1);
        drain();
        chk("err_clean_frames", 64'(err_frame), 64'd0);

        // Early in_last at (3,5), then a full frame
        fill_ramp();
        queue_patches(3, 5, 1, 0, '0, '0);
        send_img(3, 5, 1);
        chk("err_early_last", 64'(err_frame), 64'd1);
        queue_patches(7, 7, 1, 0, '0, '0);
        send_img(7, 7, 1);
        drain();
        chk("err_sticky", 64'(err_frame), 64'd1);

        // Reset mid-frame before pixel (4,2), then a clean frame
        queue_patches(4, 1, 0, 0, '0, '0);
        send_img(4, 1, 0);
        drain();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_err_frame", 64'(err_frame), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        queue_patches(7, 7, 1, 0, '0, '0);
        send_img(7, 7, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
